// File: rtl/button_conditioner.sv
// Turns raw push-button levels into clean strobes: per bit a 2-flop synchroniser,
// a sampled saturating-counter debouncer, a rising-edge press pulse and a toggle register.
module button_conditioner #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SAMPLE_CNT_MAX = 62500,
    parameter int unsigned PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] toggle
);

    localparam int unsigned SampleW = $clog2(SAMPLE_CNT_MAX);
    localparam int unsigned PulseW  = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SampleW-1:0] SampleLast = SampleW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PulseW-1:0]  PulseMax   = PulseW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0]              sync1_q, sync2_q;
    logic [SampleW-1:0]            sample_cnt_q, sample_cnt_d;
    logic                          sample_tick;
    logic [WIDTH-1:0][PulseW-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [WIDTH-1:0]              debounced_q;
    logic [WIDTH-1:0]              toggle_q, toggle_d;

    // One shared free-running sample strobe paces every bit's debouncer.
    assign sample_tick  = (sample_cnt_q == SampleLast);
    assign sample_cnt_d = sample_tick ? '0 : sample_cnt_q + SampleW'(1);

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            // Any low cycle restarts qualification; a full count saturates.
            if (!sync2_q[i]) begin
                pulse_cnt_d[i] = '0;
            end else if (sample_tick && (pulse_cnt_q[i] < PulseMax)) begin
                pulse_cnt_d[i] = pulse_cnt_q[i] + PulseW'(1);
            end
        end
    end

    always_comb begin
        debounced = '0;
        for (int i = 0; i < WIDTH; i++) begin
            debounced[i] = (pulse_cnt_q[i] == PulseMax);
        end
    end

    assign pressed  = debounced & ~debounced_q;
    assign toggle_d = toggle_q ^ pressed;
    assign toggle   = toggle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sample_cnt_q <= '0;
            pulse_cnt_q  <= '0;
            debounced_q  <= '0;
            toggle_q     <= '0;
        end else begin
            sync1_q      <= buttons;
            sync2_q      <= sync1_q;
            sample_cnt_q <= sample_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            debounced_q  <= debounced;
            toggle_q     <= toggle_d;
        end
    end

endmodule
